// File: rtl/mel_pkg.sv
// ============================================================================
// Module   : mel_pkg
// Brief    : Shared mel front-end widths and frame-scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mel_pkg;

  localparam int DATA_W  = 16;
  localparam int N_BANKS = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } mel_state_t;

endpackage

`default_nettype wire

// File: rtl/mel_chunk_buffer.sv
// ============================================================================
// Module   : mel_chunk_buffer
// Brief    : Holds one mel vector and presents the selected OUT_WIDTH chunk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mel_chunk_buffer #(
  parameter int DATA_W    = 16,
  parameter int N_BANKS   = 40,
  parameter int OUT_WIDTH = 20,
  parameter int NCH       = N_BANKS / OUT_WIDTH,
  parameter int SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                                clk,
  input  logic                                i_load,
  input  logic [N_BANKS-1:0][DATA_W-1:0]      i_vec,
  input  logic [SEL_W-1:0]                    i_sel,
  output logic [OUT_WIDTH-1:0][DATA_W-1:0]    o_chunk
);

  // Data-path only storage; no reset so it maps onto plain flops/RAM.
  logic [OUT_WIDTH-1:0][DATA_W-1:0] r_buf [NCH];

  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int k = 0; k < NCH; k++) begin
        r_buf[k] <= i_vec[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign o_chunk = r_buf[i_sel];

endmodule

`default_nettype wire

// File: rtl/mel_frame_scheduler.sv
// ============================================================================
// Module   : mel_frame_scheduler
// Brief    : Buffers mel vectors and streams them as chunks, FRAMES per utterance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mel_frame_scheduler #(
  parameter int DATA_W    = mel_pkg::DATA_W,
  parameter int N_BANKS   = mel_pkg::N_BANKS,
  parameter int OUT_WIDTH = 20,
  parameter int FRAMES    = 49
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  input  logic [N_BANKS-1:0][DATA_W-1:0]       in,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [OUT_WIDTH-1:0][DATA_W-1:0]     out,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 m_last,
  output logic                                 m_frame_last,
  output logic [$clog2(FRAMES+1)-1:0]          frame_idx
);

  import mel_pkg::*;

  localparam int c_nch     = N_BANKS / OUT_WIDTH;
  localparam int c_sel_w   = (c_nch > 1) ? $clog2(c_nch) : 1;
  localparam int c_frame_w = $clog2(FRAMES + 1);
  localparam logic [c_sel_w-1:0]   c_last_chunk = c_sel_w'(c_nch - 1);
  localparam logic [c_frame_w-1:0] c_last_frame = c_frame_w'(FRAMES - 1);

  generate
    if ((OUT_WIDTH < 1) || (N_BANKS % OUT_WIDTH != 0)) begin : g_bad_chunking
      $error("mel_frame_scheduler: N_BANKS must be an integer multiple of OUT_WIDTH");
    end
    if (FRAMES < 1) begin : g_bad_frames
      $error("mel_frame_scheduler: FRAMES must be at least 1");
    end
  endgenerate

  mel_state_t            r_state, w_state_nxt;
  logic [c_frame_w-1:0]  r_frame_cnt, w_frame_nxt;
  logic [c_sel_w-1:0]    r_chunk_cnt, w_chunk_nxt;
  logic                  w_load;
  logic                  r_busy, r_done, r_s_ready, r_m_valid, r_m_last, r_m_frame_last;

  // Handshakes are qualified by the registered state, so no input reaches an output.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame_cnt;
    w_chunk_nxt = r_chunk_cnt;
    w_load      = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
      w_frame_nxt = '0;
      w_chunk_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = LOAD;
            w_frame_nxt = '0;
            w_chunk_nxt = '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            w_load      = 1'b1;
            w_state_nxt = SEND;
            w_chunk_nxt = '0;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (r_chunk_cnt != c_last_chunk) begin
              w_chunk_nxt = r_chunk_cnt + c_sel_w'(1);
            end else if (r_frame_cnt != c_last_frame) begin
              w_frame_nxt = r_frame_cnt + c_frame_w'(1);
              w_state_nxt = LOAD;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_frame_nxt = '0;
          w_chunk_nxt = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_frame_nxt = '0;
          w_chunk_nxt = '0;
        end
      endcase
    end
  end

  // Output flags are registered from next-state values so they align with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_frame_cnt    <= '0;
      r_chunk_cnt    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_s_ready      <= 1'b0;
      r_m_valid      <= 1'b0;
      r_m_last       <= 1'b0;
      r_m_frame_last <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame_cnt    <= w_frame_nxt;
      r_chunk_cnt    <= w_chunk_nxt;
      r_busy         <= (w_state_nxt != IDLE);
      r_done         <= (w_state_nxt == DONE);
      r_s_ready      <= (w_state_nxt == LOAD);
      r_m_valid      <= (w_state_nxt == SEND);
      r_m_last       <= (w_state_nxt == SEND) && (w_chunk_nxt == c_last_chunk);
      r_m_frame_last <= (w_state_nxt == SEND) && (w_chunk_nxt == c_last_chunk)
                        && (w_frame_nxt == c_last_frame);
    end
  end

  mel_chunk_buffer #(
    .DATA_W    (DATA_W),
    .N_BANKS   (N_BANKS),
    .OUT_WIDTH (OUT_WIDTH),
    .NCH       (c_nch),
    .SEL_W     (c_sel_w)
  ) u_chunk_buffer (
    .clk     (clk),
    .i_load  (w_load),
    .i_vec   (in),
    .i_sel   (r_chunk_cnt),
    .o_chunk (out)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign m_last       = r_m_last;
  assign m_frame_last = r_m_frame_last;
  assign frame_idx    = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mel_frame_scheduler.sv
// ============================================================================
// Module   : tb_mel_frame_scheduler
// Brief    : Directed self-checking bench for mel_frame_scheduler (3 frames x 2 chunks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mel_frame_scheduler;

  localparam int DW     = 16;
  localparam int NB     = 40;
  localparam int OW     = 20;
  localparam int FRAMES = 3;
  localparam int NCH    = NB / OW;
  localparam int FW     = $clog2(FRAMES + 1);
  localparam int CHK_W  = OW * DW;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     busy, done;
  logic [NB-1:0][DW-1:0]    in_vec = '0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [OW-1:0][DW-1:0]    out_chunk;
  logic                     m_valid;
  logic                     m_ready = 1'b0;
  logic                     m_last, m_frame_last;
  logic [FW-1:0]            frame_idx;

  int n_pass  = 0;
  int n_total = 0;
  int mf = 0;
  int mk = 0;

  always #5 clk = ~clk;

  mel_frame_scheduler #(
    .DATA_W    (DW),
    .N_BANKS   (NB),
    .OUT_WIDTH (OW),
    .FRAMES    (FRAMES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .in           (in_vec),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .out          (out_chunk),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_frame_last (m_frame_last),
    .frame_idx    (frame_idx)
  );

  function automatic logic [NB-1:0][DW-1:0] vec(input int f);
    logic [NB-1:0][DW-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = DW'(f * 100 + i);
    return v;
  endfunction

  function automatic logic [OW-1:0][DW-1:0] exp_chunk(input int f, input int k);
    logic [OW-1:0][DW-1:0] c;
    for (int j = 0; j < OW; j++) c[j] = DW'(f * 100 + k * OW + j);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams from the current model position (mf, mk) to the done pulse.
  task automatic run_to_done();
    bit seen = 1'b0;
    int last_acc = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        chk("done_after_last", c - last_acc, 1);
        chk("done_frames", mf, FRAMES);
      end else begin
        s_valid = s_ready;
        if (s_ready) begin
          in_vec = vec(mf);
          chk("load_idx", frame_idx, mf);
        end
        if (m_valid) begin
          chk("chunk_data", out_chunk, exp_chunk(mf, mk));
          chk("m_last", m_last, mk == NCH - 1);
          chk("m_frame_last", m_frame_last, (mk == NCH - 1) && (mf == FRAMES - 1));
          chk("send_idx", frame_idx, mf);
          last_acc = c;
          mk++;
          if (mk == NCH) begin
            mk = 0;
            mf++;
          end
        end
        tick();
      end
    end
    chk("done_seen", seen, 1);
    chk("done_busy", busy, 1);
    s_valid = 1'b0;
    tick();
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_frame_last", m_frame_last, 0);
    chk("rst_frame_idx", frame_idx, 0);
    reset = 1'b1;
    tick();

    // Nominal utterance
    do_start();
    chk("nom_s_ready", s_ready, 1);
    chk("nom_busy", busy, 1);
    mf = 0; mk = 0;
    run_to_done();

    // Upstream gap, ignored start, backpressure
    do_start();
    for (int g = 0; g < 5; g++) begin
      start = (g == 2);
      tick();
      chk("gap_s_ready", s_ready, 1);
      chk("gap_m_valid", m_valid, 0);
      chk("gap_idx", frame_idx, 0);
    end
    start = 1'b0;
    s_valid = 1'b1;
    in_vec = vec(0);
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("bp_c0_data", out_chunk, exp_chunk(0, 0));
    chk("bp_c0_valid", m_valid, 1);
    tick();
    m_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start = (s == 0);
      chk("bp_stall_data", out_chunk, exp_chunk(0, 1));
      chk("bp_stall_last", m_last, 1);
      chk("bp_stall_flast", m_frame_last, 0);
      chk("bp_stall_s_ready", s_ready, 0);
      chk("bp_stall_valid", m_valid, 1);
      if (s < 2) tick();
    end
    start = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("bp_reload_s_ready", s_ready, 1);
    chk("bp_reload_idx", frame_idx, 1);
    chk("bp_reload_m_valid", m_valid, 0);
    mf = 1; mk = 0;
    run_to_done();

    // Abort at frame 1 chunk 0 with a simultaneous handshake
    do_start();
    s_valid = 1'b1;
    in_vec = vec(0);
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    chk("ab_load1", s_ready, 1);
    s_valid = 1'b1;
    in_vec = vec(1);
    tick();
    s_valid = 1'b0;
    chk("ab_send_idx", frame_idx, 1);
    chk("ab_send_data", out_chunk, exp_chunk(1, 0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_m_valid", m_valid, 0);
    chk("ab_done", done, 0);
    chk("ab_idx", frame_idx, 0);
    tick();
    chk("ab_no_done", done, 0);
    do_start();
    mf = 0; mk = 0;
    run_to_done();

    // Asynchronous reset mid-SEND
    do_start();
    s_valid = 1'b1;
    in_vec = vec(0);
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("ar_pre_valid", m_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_m_valid", m_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_idx", frame_idx, 0);
    tick();
    reset = 1'b1;
    s_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("ar_idle_s_ready", s_ready, 0);
      chk("ar_idle_busy", busy, 0);
    end
    s_valid = 1'b0;
    do_start();
    mf = 0; mk = 0;
    run_to_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mel_frame_scheduler.md
Name: mel_frame_scheduler

Overview:
Sequences one utterance of mel-filter-bank frames into the downstream feature path. Each N_BANKS-wide mel vector is accepted from the mel filter, buffered, and emitted as N_BANKS/OUT_WIDTH chunks over a valid/ready stream. Frames are counted up to FRAMES per utterance, with start/busy/done/abort control for the top-level recognition controller. Sits between the mel filter bank output and the feature memory / classifier input.

Parameters:
DATA_W, 16, width of one mel coefficient
N_BANKS, 40, mel coefficients per frame
OUT_WIDTH, 20, coefficients per output chunk; N_BANKS must be an integer multiple of OUT_WIDTH (elaboration-time assertion)
FRAMES, 49, frames per utterance, >=1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low; reset=0 forces the reset state
start  in  1  single-cycle request to begin an utterance
abort  in  1  synchronous abort, back to IDLE without done
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final chunk of the final frame is accepted
in  in  N_BANKS x DATA_W  mel vector from filter bank
s_valid  in  1  mel vector valid
s_ready  out  1  scheduler can accept a vector
out  out  OUT_WIDTH x DATA_W  current chunk
m_valid  out  1  chunk valid
m_ready  in  1  downstream accepts chunk
m_last  out  1  current chunk is the last of its frame
m_frame_last  out  1  current chunk is the last chunk of the last frame
frame_idx  out  $clog2(FRAMES+1)  index of the frame being loaded or sent

Behaviour:
- Reset (reset=0, async): state=IDLE, frame_cnt=0, chunk_cnt=0, busy=0, done=0, s_ready=0, m_valid=0, m_last=0, m_frame_last=0, frame_idx=0. The chunk buffer is not reset. Reset mid-utterance discards the buffered frame.
- NCH = N_BANKS/OUT_WIDTH chunks per frame.
- States: IDLE, LOAD, SEND, DONE. State is registered. s_ready, m_valid, m_last, m_frame_last and done decode from registers only, with no combinational path from s_valid or m_ready.
- IDLE: start=1 -> LOAD, frame_cnt=0. start is ignored in every other state.
- LOAD: s_ready=1. On s_valid & s_ready, capture in[] into the buffer (chunk k = in[k*OUT_WIDTH +: OUT_WIDTH]), set chunk_cnt=0, go to SEND. m_valid=0.
- SEND: m_valid=1, out=buffer chunk chunk_cnt, s_ready=0. Data and flags hold stable while m_ready=0.
  - m_last = (chunk_cnt==NCH-1).
  - m_frame_last = m_last & (frame_cnt==FRAMES-1).
- On m_valid & m_ready in SEND:
  - chunk_cnt<NCH-1: chunk_cnt++.
  - otherwise, frame_cnt<FRAMES-1: frame_cnt++, go to LOAD.
  - otherwise: go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE with frame_cnt cleared.
- Latency:
  - First chunk valid the cycle after the vector is accepted.
  - Back-to-back chunks with m_ready held high.
  - Minimum frame period is NCH+1 cycles, including the one LOAD cycle.
- abort=1 in any state: next state IDLE, counters cleared, no done pulse. abort has priority over a simultaneous handshake, and that handshake is treated as not taken.
- abort and start in the same IDLE cycle: abort wins, state stays IDLE.
- frame_idx = frame_cnt. Counters are sized so FRAMES-1 and NCH-1 fit, with no wrap within an utterance.
- NCH=1 is legal: every chunk has m_last=1.

Decomposition:
- Package mel_pkg: DATA_W, N_BANKS and the state enum typedef (IDLE, LOAD, SEND, DONE), shared with the mel filter and the feature memory writer.
- Sub-module mel_chunk_buffer: register array that loads the full vector and muxes out chunk index chunk_cnt. The FSM and counters stay in the top module.

Test Plan:
- Nominal, FRAMES=3, NCH=2, in[i]=frame*100+i, m_ready=1 -> 6 chunks in order: frame0 chunk0 = 0..19, chunk1 = 20..39. m_last on chunks 1, 3, 5. m_frame_last only on chunk 5. done pulses one cycle after chunk 5 accepted. busy falls the next cycle.
- Backpressure: m_ready toggles 1,0,0,1 -> out, m_last and m_frame_last stay stable while stalled. No chunk is skipped or duplicated. s_ready stays 0 until the last chunk of the frame is accepted.
- Upstream gaps: s_valid low 5 cycles in LOAD -> s_ready held 1, m_valid 0, frame_idx unchanged. Vector accepted on the first cycle s_valid=1.
- Abort: abort in SEND at frame 1 chunk 0 with m_ready=1 -> next cycle IDLE, busy=0, no done, frame_idx=0. A following start runs a full clean utterance.
- Async reset: drive reset=0 mid-cycle during SEND -> outputs reach reset values immediately, before the next clk edge. After release, start and s_valid are ignored until start is seen in IDLE.
- Ignored start: pulse start during LOAD and SEND -> frame_cnt is not restarted and the sequence completes normally.
